// File: rtl/dff_bank_arbiter.sv
// Shared DEPTH x WIDTH register bank written by NREQ requesters through a
// round-robin arbiter, with a sequenced one-entry-per-cycle clear engine.
module dff_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*AW-1:0]    wr_addr,
    input  logic [NREQ*WIDTH-1:0] wr_data,
    output logic [NREQ-1:0]       gnt,
    input  logic                  clr_start,
    output logic                  clr_busy,
    input  logic [AW-1:0]         rd_addr,
    output logic [WIDTH-1:0]      rd_data
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {ARB, CLEAR} state_t;

    state_t           state, state_nxt;
    logic [PW-1:0]    rr_ptr, rr_ptr_nxt;
    logic [AW-1:0]    cnt, cnt_nxt;
    logic [NREQ-1:0]  gnt_nxt;
    logic [PW-1:0]    win;
    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic [WIDTH-1:0] wr_val;
    logic [AW-1:0]    addr_a [NREQ];
    logic [WIDTH-1:0] data_a [NREQ];
    logic [WIDTH-1:0] bank   [DEPTH];

    // Winner is the set requester at the smallest rotational distance from ptr.
    function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [PW-1:0]   ptr);
        logic [PW-1:0] w;
        int            best;
        int            d;
        w    = '0;
        best = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            d = (i + NREQ - int'(ptr)) % NREQ;
            if (r[i] && d < best) begin
                best = d;
                w    = PW'(i);
            end
        end
        return w;
    endfunction

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_a[i] = wr_addr[i*AW +: AW];
            data_a[i] = wr_data[i*WIDTH +: WIDTH];
        end
    end

    assign win = rr_pick(req, rr_ptr);

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        cnt_nxt    = cnt;
        gnt_nxt    = '0;
        wr_en      = 1'b0;
        wr_idx     = addr_a[win];
        wr_val     = data_a[win];
        if (state == ARB) begin
            // A clear command pre-empts any write requested in the same cycle.
            if (clr_start) begin
                state_nxt = CLEAR;
                cnt_nxt   = '0;
            end else if (|req) begin
                wr_en      = 1'b1;
                gnt_nxt    = NREQ'(1) << win;
                rr_ptr_nxt = (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
            end
        end else begin
            wr_en   = 1'b1;
            wr_idx  = cnt;
            wr_val  = '0;
            cnt_nxt = cnt + 1'b1;
            if (cnt == AW'(DEPTH-1)) begin
                state_nxt = ARB;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state  <= ARB;
            rr_ptr <= '0;
            cnt    <= '0;
            gnt    <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            cnt    <= cnt_nxt;
            gnt    <= gnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
        end else if (wr_en) begin
            bank[wr_idx] <= wr_val;
        end
    end

    assign clr_busy = (state == CLEAR);
    assign rd_data  = bank[rd_addr];

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Bench for dff_bank_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_dff_bank_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic                  clk = 1'b0;
    logic                  clr;
    logic [NREQ-1:0]       req;
    logic [NREQ*AW-1:0]    wr_addr;
    logic [NREQ*WIDTH-1:0] wr_data;
    logic [NREQ-1:0]       gnt;
    logic                  clr_start;
    logic                  clr_busy;
    logic [AW-1:0]         rd_addr;
    logic [WIDTH-1:0]      rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [WIDTH-1:0] m_bank [DEPTH];
    logic [NREQ-1:0]  m_gnt      = '0;
    int               m_ptr      = 0;
    logic             m_clearing = 1'b0;
    int               m_cnt      = 0;
    int               mi;

    dff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .clr       (clr),
        .req       (req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .gnt       (gnt),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int i, input int a, input logic [WIDTH-1:0] d);
        wr_addr[i*AW +: AW]       = a[AW-1:0];
        wr_data[i*WIDTH +: WIDTH] = d;
    endtask

    task automatic rd_chk(input string name, input int a, input logic [WIDTH-1:0] exp);
        rd_addr = a[AW-1:0];
        #1;
        check(name, 32'(rd_data), 32'(exp));
    endtask

    // Behavioural model: one decision per rising edge from the sampled inputs.
    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int k = 0; k < DEPTH; k++) m_bank[k] = '0;
            m_ptr      = 0;
            m_clearing = 1'b0;
            m_cnt      = 0;
            m_gnt      = '0;
        end else if (m_clearing) begin
            m_bank[m_cnt] = '0;
            m_cnt++;
            m_gnt = '0;
            if (m_cnt == DEPTH) m_clearing = 1'b0;
        end else if (clr_start) begin
            m_clearing = 1'b1;
            m_cnt      = 0;
            m_gnt      = '0;
        end else begin
            m_gnt = '0;
            for (int k = 0; k < NREQ; k++) begin
                mi = (m_ptr + k) % NREQ;
                if (m_gnt == '0 && req[mi]) begin
                    m_bank[wr_addr[mi*AW +: AW]] = wr_data[mi*WIDTH +: WIDTH];
                    m_gnt = NREQ'(1) << mi;
                    m_ptr = (mi + 1) % NREQ;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_gnt", 32'(gnt), 32'(m_gnt));
        check("cyc_busy", 32'(clr_busy), 32'(m_clearing));
        check("cyc_rd", 32'(rd_data), 32'(m_bank[rd_addr]));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b0; req = '0; wr_addr = '0; wr_data = '0; clr_start = 1'b0; rd_addr = '0;
        tick(); tick();
        clr = 1'b1;

        // Put data in the bank, then reset and confirm it is gone.
        req = 4'b0001; set_wr(0, 3, 8'h5A);
        tick();
        req = '0;
        check("pre_gnt", 32'(gnt), 32'h1);
        rd_chk("pre_rd3", 3, 8'h5A);
        clr = 1'b0;
        #1;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_busy", 32'(clr_busy), 32'h0);
        for (int k = 0; k < DEPTH; k++) rd_chk("rst_rd", k, 8'h00);
        tick();
        clr = 1'b1;
        req = 4'b0001; set_wr(0, 0, 8'hA5);
        tick();
        req = '0;
        check("rst_gnt0", 32'(gnt), 32'h1);
        rd_chk("rst_rdA5", 0, 8'hA5);

        // Round-robin over four continuously requesting masters.
        clr = 1'b0; #1; clr = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_wr(i, i, 8'(8'h10 + i));
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rr_gnt", 32'(gnt), 32'(1 << (k % 4)));
        end
        req = '0;
        for (int i = 0; i < NREQ; i++) rd_chk("rr_rd", i, 8'(8'h10 + i));

        // Pointer moved to 2: requester 0 wins over 1, then 1, then solo 2.
        req = 4'b0010; tick(); check("fair_g1", 32'(gnt), 32'h2);
        req = 4'b0011; tick(); check("fair_g0", 32'(gnt), 32'h1);
        req = 4'b0010; tick(); check("fair_g1b", 32'(gnt), 32'h2);
        req = 4'b0100; tick(); check("fair_g2", 32'(gnt), 32'h4);
        req = '0;      tick(); check("fair_idle", 32'(gnt), 32'h0);

        // Fill with 0xFF and run the clear sequence.
        req = 4'b0001;
        for (int a = 0; a < DEPTH; a++) begin
            set_wr(0, a, 8'hFF);
            tick();
        end
        req = '0;
        for (int a = 0; a < DEPTH; a++) rd_chk("fill_rd", a, 8'hFF);
        clr_start = 1'b1; tick(); clr_start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            check("clr_busy", 32'(clr_busy), 32'(c <= 4));
            for (int k = 0; k < DEPTH; k++)
                rd_chk("clr_rd", k, (k + 2 <= c) ? 8'h00 : 8'hFF);
            tick();
        end

        // clr_start and a request in the same cycle.
        req = 4'b0010; set_wr(1, 2, 8'h3C); clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check("col_gnt", 32'(gnt), 32'h0);
            check("col_busy", 32'(clr_busy), 32'h1);
            tick();
        end
        check("col_gnt5", 32'(gnt), 32'h0);
        check("col_busy5", 32'(clr_busy), 32'h0);
        rd_chk("col_rd_pre", 2, 8'h00);
        tick();
        check("col_gnt6", 32'(gnt), 32'h2);
        req = '0;
        rd_chk("col_rd", 2, 8'h3C);

        // Reset during the second clear cycle.
        req = 4'b1000; set_wr(3, 3, 8'h77);
        tick();
        req = '0;
        check("mid_pre_gnt", 32'(gnt), 32'h8);
        rd_chk("mid_pre_rd", 3, 8'h77);
        clr_start = 1'b1; tick(); clr_start = 1'b0;
        tick();
        clr = 1'b0;
        #1;
        check("mid_busy", 32'(clr_busy), 32'h0);
        check("mid_gnt", 32'(gnt), 32'h0);
        for (int k = 0; k < DEPTH; k++) rd_chk("mid_rd", k, 8'h00);
        tick();
        clr = 1'b1;
        req = 4'b1111;
        tick();
        check("mid_prio0", 32'(gnt), 32'h1);
        req = '0;
        tick();

        // Randomized traffic, checked each cycle by the compare process.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) req = '0;
            else req = 4'($urandom);
            wr_addr   = 8'($urandom);
            wr_data   = $urandom;
            rd_addr   = 2'($urandom);
            clr_start = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 199) == 0) begin
                clr = 1'b0; #1; clr = 1'b1;
            end
            tick();
        end
        req = '0; clr_start = 1'b0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
